// File: rtl/sponge_ctrl.sv
// SHAKE256 sponge sequencer: steps the padder and Keccak-f[1600] core through
// absorb, then squeezes OUT_BYTES of output in rate-sized handshaked beats.
module sponge_ctrl #(
  parameter int unsigned RATE_BYTES = 136,
  parameter int unsigned OUT_BYTES  = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  output logic        pad_start,
  output logic        next_block,
  input  logic        pad_done,
  input  logic        msg_last_block,
  output logic        state_clear,
  output logic        absorb_en,
  output logic        perm_start,
  input  logic        perm_done,
  output logic        squeeze_valid,
  input  logic        squeeze_ready,
  output logic [7:0]  squeeze_bytes,
  output logic        busy,
  output logic        done,
  output logic [7:0]  block_count,
  output logic [15:0] squeeze_count,
  output logic [2:0]  debug_ctrl_state
);

  localparam int unsigned CW = 16;
  localparam int unsigned BW = 8;
  localparam logic [CW-1:0] OUT_W  = CW'(OUT_BYTES);
  localparam logic [CW-1:0] RATE_W = CW'(RATE_BYTES);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CLEAR     = 3'd1,
    S_PAD_WAIT  = 3'd2,
    S_ABSORB    = 3'd3,
    S_PERM      = 3'd4,
    S_PERM_WAIT = 3'd5,
    S_SQUEEZE   = 3'd6,
    S_DONE      = 3'd7
  } state_t;

  typedef enum logic {
    PH_ABSORB  = 1'b0,
    PH_SQUEEZE = 1'b1
  } phase_t;

  state_t          r_state;
  phase_t          r_phase;
  logic            r_last;
  logic [BW-1:0]   r_block_count;
  logic [CW-1:0]   r_squeeze_count;
  logic [BW-1:0]   r_squeeze_bytes;
  logic            r_pad_start, r_next_block, r_state_clear, r_absorb_en;
  logic            r_perm_start, r_squeeze_valid, r_busy, r_done;

  state_t          w_next;
  logic            w_start_go, w_pad_accept, w_next_block, w_to_squeeze, w_hs;
  logic [CW-1:0]   w_remaining;
  logic [BW-1:0]   w_beat;

  // Next-state decode; abort overrides every transition and strobe.
  always_comb begin
    w_next       = r_state;
    w_start_go   = 1'b0;
    w_pad_accept = 1'b0;
    w_next_block = 1'b0;
    w_to_squeeze = 1'b0;
    w_hs         = 1'b0;
    w_remaining  = OUT_W - r_squeeze_count;
    w_beat       = (w_remaining > RATE_W) ? BW'(RATE_BYTES) : BW'(w_remaining);
    case (r_state)
      S_IDLE: if (start) begin
        w_next     = S_CLEAR;
        w_start_go = 1'b1;
      end
      S_CLEAR:    w_next = S_PAD_WAIT;
      S_PAD_WAIT: if (pad_done) begin
        w_next       = S_ABSORB;
        w_pad_accept = 1'b1;
      end
      S_ABSORB:   w_next = S_PERM;
      S_PERM:     w_next = S_PERM_WAIT;
      S_PERM_WAIT: if (perm_done) begin
        if (r_phase == PH_ABSORB && !r_last) begin
          w_next       = S_PAD_WAIT;
          w_next_block = 1'b1;
        end else begin
          w_next       = S_SQUEEZE;
          w_to_squeeze = (r_phase == PH_ABSORB);
        end
      end
      S_SQUEEZE: if (r_squeeze_valid && squeeze_ready) begin
        w_hs   = 1'b1;
        w_next = (w_remaining <= RATE_W) ? S_DONE : S_PERM;
      end
      S_DONE:     w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
    if (abort) begin
      w_next       = S_IDLE;
      w_start_go   = 1'b0;
      w_pad_accept = 1'b0;
      w_next_block = 1'b0;
      w_to_squeeze = 1'b0;
      w_hs         = 1'b0;
    end
  end

  // State register; outputs are registered from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_phase         <= PH_ABSORB;
      r_last          <= 1'b0;
      r_block_count   <= '0;
      r_squeeze_count <= '0;
      r_squeeze_bytes <= '0;
      r_pad_start     <= 1'b0;
      r_next_block    <= 1'b0;
      r_state_clear   <= 1'b0;
      r_absorb_en     <= 1'b0;
      r_perm_start    <= 1'b0;
      r_squeeze_valid <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      r_state         <= w_next;
      r_pad_start     <= (w_next == S_CLEAR);
      r_state_clear   <= (w_next == S_CLEAR);
      r_absorb_en     <= (w_next == S_ABSORB);
      r_perm_start    <= (w_next == S_PERM);
      r_squeeze_valid <= (w_next == S_SQUEEZE);
      r_squeeze_bytes <= (w_next == S_SQUEEZE) ? w_beat : '0;
      r_busy          <= (w_next != S_IDLE);
      r_done          <= (w_next == S_DONE);
      r_next_block    <= w_next_block;
      if (w_start_go) begin
        r_block_count   <= '0;
        r_squeeze_count <= '0;
        r_phase         <= PH_ABSORB;
        r_last          <= 1'b0;
      end
      if (w_pad_accept) begin
        r_last <= msg_last_block;
        if (r_block_count != 8'hFF) r_block_count <= r_block_count + 8'd1;
      end
      if (w_to_squeeze) r_phase <= PH_SQUEEZE;
      if (w_hs) r_squeeze_count <= r_squeeze_count + CW'(r_squeeze_bytes);
    end
  end

  assign pad_start        = r_pad_start;
  assign next_block       = r_next_block;
  assign state_clear      = r_state_clear;
  assign absorb_en        = r_absorb_en;
  assign perm_start       = r_perm_start;
  assign squeeze_valid    = r_squeeze_valid;
  assign squeeze_bytes    = r_squeeze_bytes;
  assign busy             = r_busy;
  assign done             = r_done;
  assign block_count      = r_block_count;
  assign squeeze_count    = r_squeeze_count;
  assign debug_ctrl_state = r_state;

endmodule

// File: tb/tb_sponge_ctrl.sv
// Bench for sponge_ctrl: two instances (64 and 300 output bytes) driven on the
// falling edge; expected beats and pulse counts come from a transaction-level model.
module tb_sponge_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, abort, pad_done, msg_last_block, perm_done, squeeze_ready;
  logic start_i[2];
  logic pad_start_o[2], next_block_o[2], state_clear_o[2], absorb_en_o[2];
  logic perm_start_o[2], squeeze_valid_o[2], busy_o[2], done_o[2];
  logic [7:0]  squeeze_bytes_o[2], block_count_o[2];
  logic [15:0] squeeze_count_o[2];
  logic [2:0]  dbg_o[2];

  int sel = 0;
  int vectors = 0;
  int errors = 0;
  int n_nb = 0, n_ps = 0, n_done = 0;

  sponge_ctrl #(.RATE_BYTES(136), .OUT_BYTES(64)) u_dut64 (
    .clk(clk), .reset(reset), .start(start_i[0]), .abort(abort),
    .pad_start(pad_start_o[0]), .next_block(next_block_o[0]),
    .pad_done(pad_done), .msg_last_block(msg_last_block),
    .state_clear(state_clear_o[0]), .absorb_en(absorb_en_o[0]),
    .perm_start(perm_start_o[0]), .perm_done(perm_done),
    .squeeze_valid(squeeze_valid_o[0]), .squeeze_ready(squeeze_ready),
    .squeeze_bytes(squeeze_bytes_o[0]), .busy(busy_o[0]), .done(done_o[0]),
    .block_count(block_count_o[0]), .squeeze_count(squeeze_count_o[0]),
    .debug_ctrl_state(dbg_o[0]));

  sponge_ctrl #(.RATE_BYTES(136), .OUT_BYTES(300)) u_dut300 (
    .clk(clk), .reset(reset), .start(start_i[1]), .abort(abort),
    .pad_start(pad_start_o[1]), .next_block(next_block_o[1]),
    .pad_done(pad_done), .msg_last_block(msg_last_block),
    .state_clear(state_clear_o[1]), .absorb_en(absorb_en_o[1]),
    .perm_start(perm_start_o[1]), .perm_done(perm_done),
    .squeeze_valid(squeeze_valid_o[1]), .squeeze_ready(squeeze_ready),
    .squeeze_bytes(squeeze_bytes_o[1]), .busy(busy_o[1]), .done(done_o[1]),
    .block_count(block_count_o[1]), .squeeze_count(squeeze_count_o[1]),
    .debug_ctrl_state(dbg_o[1]));

  // Pulse counters for the instance under test.
  always @(negedge clk) begin
    if (next_block_o[sel]) n_nb++;
    if (perm_start_o[sel]) n_ps++;
    if (done_o[sel])       n_done++;
  end

  task automatic finish_perm();
    int d;
    d = $urandom_range(0, 4);
    repeat (d) @(negedge clk);
    perm_done = 1'b1;
    @(negedge clk);
    perm_done = 1'b0;
  endtask

  task automatic go_to_perm_wait(input int s);
    sel = s;
    start_i[s] = 1'b1; @(negedge clk); start_i[s] = 1'b0;
    @(negedge clk);
    pad_done = 1'b1; msg_last_block = 1'b1; @(negedge clk);
    pad_done = 1'b0; msg_last_block = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  // One full hash checked against the expected beat list and pulse totals.
  task automatic run_hash(input int s, input int nblocks, input int stall, input bit stray);
    int q[$];
    int rem, acc, st, d, out, exp_bc;
    int base_nb, base_ps, base_done;
    out = (s == 0) ? 64 : 300;
    rem = out;
    while (rem > 0) begin
      q.push_back((rem < 136) ? rem : 136);
      rem -= q[$];
    end
    sel = s;
    base_nb = n_nb; base_ps = n_ps; base_done = n_done;
    start_i[s] = 1'b1; @(negedge clk); start_i[s] = 1'b0;
    vectors++;
    if (pad_start_o[s] !== 1'b1 || state_clear_o[s] !== 1'b1 || busy_o[s] !== 1'b1) begin
      errors++;
      $display("FAIL clear_pulse: pad_start=%0b state_clear=%0b busy=%0b, expected 1 1 1",
               pad_start_o[s], state_clear_o[s], busy_o[s]);
    end
    vectors++;
    if (block_count_o[s] !== 8'd0 || squeeze_count_o[s] !== 16'd0) begin
      errors++;
      $display("FAIL start_clears_counts: block_count=%0d squeeze_count=%0d, expected 0 0",
               block_count_o[s], squeeze_count_o[s]);
    end
    @(negedge clk);
    for (int b = 0; b < nblocks; b++) begin
      if (stray && b == 0) begin
        perm_done = 1'b1; squeeze_ready = 1'b1; start_i[s] = 1'b1;
        @(negedge clk);
        perm_done = 1'b0; squeeze_ready = 1'b0; start_i[s] = 1'b0;
        vectors++;
        if (dbg_o[s] !== 3'd2) begin
          errors++;
          $display("FAIL stray_in_pad_wait: state=%0d, expected 2", dbg_o[s]);
        end
      end
      d = $urandom_range(0, 3);
      repeat (d) @(negedge clk);
      pad_done = 1'b1; msg_last_block = (b == nblocks - 1);
      @(negedge clk);
      pad_done = 1'b0; msg_last_block = 1'($urandom_range(0, 1));
      exp_bc = (b + 1 > 255) ? 255 : b + 1;
      vectors++;
      if (absorb_en_o[s] !== 1'b1 || block_count_o[s] !== 8'(exp_bc)) begin
        errors++;
        $display("FAIL absorb: absorb_en=%0b block_count=%0d, expected 1 %0d",
                 absorb_en_o[s], block_count_o[s], exp_bc);
      end
      @(negedge clk);
      vectors++;
      if (perm_start_o[s] !== 1'b1) begin
        errors++;
        $display("FAIL absorb_perm_start: perm_start=%0b, expected 1", perm_start_o[s]);
      end
      @(negedge clk);
      if (stray && b == 0) begin
        pad_done = 1'b1; start_i[s] = 1'b1; squeeze_ready = 1'b1;
        @(negedge clk);
        pad_done = 1'b0; start_i[s] = 1'b0; squeeze_ready = 1'b0;
        vectors++;
        if (dbg_o[s] !== 3'd5 || block_count_o[s] !== 8'd1) begin
          errors++;
          $display("FAIL stray_in_perm_wait: state=%0d block_count=%0d, expected 5 1",
                   dbg_o[s], block_count_o[s]);
        end
      end
      finish_perm();
      vectors++;
      if (b < nblocks - 1) begin
        if (next_block_o[s] !== 1'b1 || dbg_o[s] !== 3'd2) begin
          errors++;
          $display("FAIL next_block: next_block=%0b state=%0d, expected 1 2",
                   next_block_o[s], dbg_o[s]);
        end
      end else if (squeeze_valid_o[s] !== 1'b1) begin
        errors++;
        $display("FAIL enter_squeeze: squeeze_valid=%0b, expected 1", squeeze_valid_o[s]);
      end
    end
    acc = 0;
    foreach (q[k]) begin
      vectors++;
      if (squeeze_valid_o[s] !== 1'b1 || squeeze_bytes_o[s] !== 8'(q[k])) begin
        errors++;
        $display("FAIL beat%0d: valid=%0b bytes=%0d, expected 1 %0d",
                 k, squeeze_valid_o[s], squeeze_bytes_o[s], q[k]);
      end
      st = (stall < 0) ? $urandom_range(0, 3) : stall;
      for (int i = 0; i < st; i++) begin
        @(negedge clk);
        vectors++;
        if (squeeze_valid_o[s] !== 1'b1 || squeeze_bytes_o[s] !== 8'(q[k]) ||
            squeeze_count_o[s] !== 16'(acc)) begin
          errors++;
          $display("FAIL stall_hold: valid=%0b bytes=%0d count=%0d, expected 1 %0d %0d",
                   squeeze_valid_o[s], squeeze_bytes_o[s], squeeze_count_o[s], q[k], acc);
        end
      end
      squeeze_ready = 1'b1; @(negedge clk); squeeze_ready = 1'b0;
      acc += q[k];
      vectors++;
      if (squeeze_count_o[s] !== 16'(acc) || squeeze_valid_o[s] !== 1'b0) begin
        errors++;
        $display("FAIL handshake: count=%0d valid=%0b, expected %0d 0",
                 squeeze_count_o[s], squeeze_valid_o[s], acc);
      end
      if (k == q.size() - 1) begin
        vectors++;
        if (done_o[s] !== 1'b1) begin
          errors++;
          $display("FAIL done_pulse: done=%0b, expected 1", done_o[s]);
        end
        @(negedge clk);
        vectors++;
        if (done_o[s] !== 1'b0 || busy_o[s] !== 1'b0 || dbg_o[s] !== 3'd0) begin
          errors++;
          $display("FAIL back_to_idle: done=%0b busy=%0b state=%0d, expected 0 0 0",
                   done_o[s], busy_o[s], dbg_o[s]);
        end
      end else begin
        vectors++;
        if (perm_start_o[s] !== 1'b1) begin
          errors++;
          $display("FAIL squeeze_perm_start: perm_start=%0b, expected 1", perm_start_o[s]);
        end
        @(negedge clk);
        finish_perm();
      end
    end
    exp_bc = (nblocks > 255) ? 255 : nblocks;
    vectors++;
    if (block_count_o[s] !== 8'(exp_bc) || squeeze_count_o[s] !== 16'(out)) begin
      errors++;
      $display("FAIL final_counts: block_count=%0d squeeze_count=%0d, expected %0d %0d",
               block_count_o[s], squeeze_count_o[s], exp_bc, out);
    end
    vectors++;
    if (n_nb - base_nb != nblocks - 1 || n_ps - base_ps != nblocks + q.size() - 1 ||
        n_done - base_done != 1) begin
      errors++;
      $display("FAIL pulse_totals: next_block=%0d perm_start=%0d done=%0d, expected %0d %0d 1",
               n_nb - base_nb, n_ps - base_ps, n_done - base_done,
               nblocks - 1, nblocks + q.size() - 1);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if ({pad_start_o[i], next_block_o[i], state_clear_o[i], absorb_en_o[i], perm_start_o[i],
           squeeze_valid_o[i], busy_o[i], done_o[i], squeeze_bytes_o[i], block_count_o[i],
           squeeze_count_o[i], dbg_o[i]} !== 51'd0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d: state=%0d busy=%0b counts=%0d/%0d, expected all 0",
                 i, dbg_o[i], busy_o[i], block_count_o[i], squeeze_count_o[i]);
      end
    end
  endtask

  task automatic test_single_block();   run_hash(0, 1, 0, 1'b0);  endtask
  task automatic test_two_blocks();     run_hash(0, 2, -1, 1'b0); endtask
  task automatic test_multi_beat();     run_hash(1, 1, 0, 1'b0);  endtask
  task automatic test_backpressure();   run_hash(1, 2, 10, 1'b0); endtask
  task automatic test_stray();          run_hash(0, 2, -1, 1'b1); endtask
  task automatic test_saturation();     run_hash(0, 257, 0, 1'b0); endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 8; n++)
      run_hash(int'($urandom_range(0, 1)), int'($urandom_range(1, 4)), -1, 1'b0);
  endtask

  task automatic test_start_abort_idle();
    sel = 0;
    start_i[0] = 1'b1; abort = 1'b1; @(negedge clk);
    start_i[0] = 1'b0; abort = 1'b0;
    vectors++;
    if (dbg_o[0] !== 3'd0 || busy_o[0] !== 1'b0 || pad_start_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL start_abort_idle: state=%0d busy=%0b pad_start=%0b, expected 0 0 0",
               dbg_o[0], busy_o[0], pad_start_o[0]);
    end
  endtask

  task automatic test_abort();
    int base_done;
    base_done = n_done;
    go_to_perm_wait(1);
    abort = 1'b1; perm_done = 1'b1; @(negedge clk); abort = 1'b0; perm_done = 1'b0;
    vectors++;
    if (dbg_o[1] !== 3'd0 || busy_o[1] !== 1'b0 || squeeze_valid_o[1] !== 1'b0 ||
        block_count_o[1] !== 8'd1) begin
      errors++;
      $display("FAIL abort_perm_wait: state=%0d busy=%0b valid=%0b block_count=%0d, expected 0 0 0 1",
               dbg_o[1], busy_o[1], squeeze_valid_o[1], block_count_o[1]);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (n_done != base_done) begin
      errors++;
      $display("FAIL abort_no_done: done pulses=%0d, expected 0", n_done - base_done);
    end
  endtask

  task automatic test_reset_mid();
    go_to_perm_wait(0);
    finish_perm();
    vectors++;
    if (squeeze_valid_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_setup: squeeze_valid=%0b, expected 1", squeeze_valid_o[0]);
    end
    reset = 1'b1; abort = 1'b1; squeeze_ready = 1'b1; @(negedge clk);
    reset = 1'b0; abort = 1'b0; squeeze_ready = 1'b0;
    test_reset();
  endtask

  initial begin
    reset = 1'b1; abort = 1'b0; pad_done = 1'b0; msg_last_block = 1'b0;
    perm_done = 1'b0; squeeze_ready = 1'b0; start_i[0] = 1'b0; start_i[1] = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_single_block();
    test_two_blocks();
    test_multi_beat();
    test_backpressure();
    test_stray();
    test_start_abort_idle();
    test_abort();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
